// File: rtl/risc_datapath_pkg.sv
// Purpose : shared constants for the RISC datapath: opcodes, IR field positions, bus sources.
// Latency : n/a (package only).
// Backpressure: n/a.
package risc_datapath_pkg;

    // Opcodes, IR[31:27]
    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHRA = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    // IR field bit positions
    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;
    localparam int IR_C_HI  = 18;

    // Bus sources other than the live ALU output, in descending priority
    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_REG,
        SRC_BA,
        SRC_PC,
        SRC_IR,
        SRC_MAR,
        SRC_MDR,
        SRC_HI,
        SRC_LO,
        SRC_Y,
        SRC_ZHI,
        SRC_ZLO,
        SRC_INPORT,
        SRC_CSIGN
    } bus_src_t;

endpackage

// File: rtl/risc_datapath_alu.sv
// Purpose : combinational ALU, opcode + A + B -> 64-bit result {hi, lo}.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output always valid for current inputs.
// Ports: opcode (IR[31:27]), a (Y register), b (bus), result (mul/div use both halves,
//        all other operations return their value in the low word with a zero high word).
module risc_alu
    import risc_datapath_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic [4:0]         shamt;
    logic [63:0]        rot;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        b_div;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quot;
    logic [31:0]        rem;

    always_comb begin
        shamt = b[4:0];
        a_ext = {{32{a[31]}}, a};
        b_ext = {{32{b[31]}}, b};
        rot   = '0;

        // Signed divide done on magnitudes so INT_MIN / -1 never reaches a signed divider.
        a_mag = a[31] ? (~a + 32'd1) : a;
        b_mag = b[31] ? (~b + 32'd1) : b;
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quot  = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        rem   = a[31] ? (~r_mag + 32'd1) : r_mag;

        result = {32'd0, b};
        case (opcode)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: result = {32'd0, a + b};
            OP_SUB:          result = {32'd0, a - b};
            OP_AND, OP_ANDI: result = {32'd0, a & b};
            OP_OR,  OP_ORI:  result = {32'd0, a | b};
            OP_NOT:          result = {32'd0, ~b};
            OP_NEG:          result = {32'd0, ~b + 32'd1};
            OP_SHR:          result = {32'd0, a >> shamt};
            OP_SHRA:         result = {32'd0, $signed(a) >>> shamt};
            OP_SHL:          result = {32'd0, a << shamt};
            OP_ROR: begin
                rot    = {a, a} >> shamt;
                result = {32'd0, rot[31:0]};
            end
            OP_ROL: begin
                rot    = {a, a} << shamt;
                result = {32'd0, rot[63:32]};
            end
            OP_MUL:          result = a_ext * b_ext;
            OP_DIV:          result = (b == 32'd0) ? {a, 32'd0} : {rem, quot};
            default:         result = {32'd0, b};
        endcase
    end

endmodule

// File: rtl/risc_datapath.sv
// Purpose : single-bus 32-bit RISC datapath (regfile, PC, IR, MAR/MDR + memory, Y/Z, HI/LO, I/O ports).
// Latency : bus/ALU/memory read combinational; every register updates on the next rising clock edge.
// Backpressure: none; the external control unit owns every strobe, the block holds no sequencing state.
// Ports: clock, clear (sync active-low; loads PC<=pc, IR<=ir, zeroes the rest), pc_immediate,
//        per-register load (*i) / drive (*o) strobes, mem_read/mem_write, gra/grb/grc/rin/rout/baout,
//        input_unit, bus_out (live bus), output_unit (output-port register).
module risc_datapath
    import risc_datapath_pkg::*;
#(
    parameter int MEM_WORDS = 512
)
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] pc_immediate,
    input  logic        pci,
    input  logic        pco,
    input  logic        iri,
    input  logic        iro,
    input  logic        mari,
    input  logic        maro,
    input  logic        mdri,
    input  logic        mdro,
    input  logic        hii,
    input  logic        hio,
    input  logic        loi,
    input  logic        loo,
    input  logic        ryi,
    input  logic        ryo,
    input  logic        rzhi,
    input  logic        rzli,
    input  logic        rzho,
    input  logic        rzlo,
    input  logic        rzo,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        ipi,
    input  logic        ipo,
    input  logic        opi,
    input  logic [31:0] input_unit,
    input  logic        csigno,
    input  logic        gra,
    input  logic        grb,
    input  logic        grc,
    input  logic        rin,
    input  logic        rout,
    input  logic        baout,
    output logic [31:0] bus_out,
    output logic [31:0] output_unit
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   regs [16];
    logic [31:0]   mem  [MEM_WORDS];
    logic [31:0]   pc_q, ir_q, mdr_q, y_q, zhi_q, zlo_q, hi_q, lo_q, inport_q;
    logic [AW-1:0] mar_q;

    logic [3:0]    sel;
    logic [31:0]   csign;
    logic [31:0]   mem_rdata;
    logic [31:0]   bus_base;
    logic [31:0]   bus;
    logic [63:0]   alu_res;
    logic          zo_wins;
    bus_src_t      bus_src;

    assign sel = (gra ? ir_q[IR_RA_HI:IR_RA_LO] : 4'd0)
               | (grb ? ir_q[IR_RB_HI:IR_RB_LO] : 4'd0)
               | (grc ? ir_q[IR_RC_HI:IR_RC_LO] : 4'd0);

    assign csign     = {{(31 - IR_C_HI){ir_q[IR_C_HI]}}, ir_q[IR_C_HI:0]};
    assign mem_rdata = mem[mar_q];

    // Priority select over every source except the live ALU output (rzo).
    always_comb begin
        bus_src = SRC_NONE;
        if      (rout)   bus_src = SRC_REG;
        else if (baout)  bus_src = SRC_BA;
        else if (pco)    bus_src = SRC_PC;
        else if (iro)    bus_src = SRC_IR;
        else if (maro)   bus_src = SRC_MAR;
        else if (mdro)   bus_src = SRC_MDR;
        else if (hio)    bus_src = SRC_HI;
        else if (loo)    bus_src = SRC_LO;
        else if (ryo)    bus_src = SRC_Y;
        else if (rzho)   bus_src = SRC_ZHI;
        else if (rzlo)   bus_src = SRC_ZLO;
        else if (ipo)    bus_src = SRC_INPORT;
        else if (csigno) bus_src = SRC_CSIGN;
    end

    always_comb begin
        case (bus_src)
            SRC_REG:    bus_base = regs[sel];
            SRC_BA:     bus_base = (sel == 4'd0) ? 32'd0 : regs[sel];
            SRC_PC:     bus_base = pc_q;
            SRC_IR:     bus_base = ir_q;
            SRC_MAR:    bus_base = {{(32 - AW){1'b0}}, mar_q};
            SRC_MDR:    bus_base = mdr_q;
            SRC_HI:     bus_base = hi_q;
            SRC_LO:     bus_base = lo_q;
            SRC_Y:      bus_base = y_q;
            SRC_ZHI:    bus_base = zhi_q;
            SRC_ZLO:    bus_base = zlo_q;
            SRC_INPORT: bus_base = inport_q;
            SRC_CSIGN:  bus_base = csign;
            default:    bus_base = 32'd0;
        endcase
    end

    // The ALU's B operand is the bus, yet rzo puts the ALU on the bus. To keep that
    // loop-free, B is always the value the bus would carry without rzo: identical to
    // the bus whenever rzo does not win, and the lower-priority source when it does.
    assign zo_wins = rzo && !(rout | baout | pco | iro | maro | mdro | hio | loo | ryo | rzho | rzlo);

    risc_alu u_alu (
        .opcode (ir_q[IR_OP_HI:IR_OP_LO]),
        .a      (y_q),
        .b      (bus_base),
        .result (alu_res)
    );

    assign bus     = zo_wins ? alu_res[31:0] : bus_base;
    assign bus_out = bus;

    always_ff @(posedge clock) begin
        if (!clear) begin
            pc_q        <= pc;
            ir_q        <= ir;
            mar_q       <= '0;
            mdr_q       <= '0;
            y_q         <= '0;
            zhi_q       <= '0;
            zlo_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            inport_q    <= '0;
            output_unit <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            // Non-blocking update: rin together with rout stores the pre-edge register value.
            if (rin)  regs[sel] <= bus;
            if (pci)  pc_q      <= pco ? (pc_q + pc_immediate) : bus;
            if (iri)  ir_q      <= bus;
            if (mari) mar_q     <= bus[AW-1:0];
            if (mdri) mdr_q     <= mem_read ? mem_rdata : bus;
            if (hii)  hi_q      <= bus;
            if (loi)  lo_q      <= bus;
            if (ryi)  y_q       <= bus;
            if (rzhi) zhi_q     <= alu_res[63:32];
            if (rzli) zlo_q     <= alu_res[31:0];
            if (ipi)  inport_q  <= input_unit;
            if (opi)  output_unit <= bus;
        end
    end

    // Memory is never cleared; a write is still suppressed during reset.
    always_ff @(posedge clock) begin
        if (clear && mem_write) mem[mar_q] <= mdr_q;
    end

endmodule

// File: tb/tb_risc_datapath.sv
module tb_risc_datapath;

    typedef struct packed {
        logic pci, pco, iri, iro, mari, maro, mdri, mdro, hii, hio, loi, loo, ryi, ryo;
        logic rzhi, rzli, rzho, rzlo, rzo, mem_read, mem_write, ipi, ipo, opi, csigno;
        logic gra, grb, grc, rin, rout, baout;
    } ctl_t;

    logic        clock;
    logic        clear;
    logic [31:0] pc_in, ir_in, pc_imm, in_unit;
    logic [31:0] bus_out, output_unit;
    ctl_t        c;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo, m_in, m_out;
    logic [8:0]  m_mar;
    logic [31:0] m_mem [512];
    bit          m_memv [512];

    risc_datapath #(.MEM_WORDS(512)) dut (
        .clock(clock), .clear(clear), .pc(pc_in), .ir(ir_in), .pc_immediate(pc_imm),
        .pci(c.pci), .pco(c.pco), .iri(c.iri), .iro(c.iro), .mari(c.mari), .maro(c.maro),
        .mdri(c.mdri), .mdro(c.mdro), .hii(c.hii), .hio(c.hio), .loi(c.loi), .loo(c.loo),
        .ryi(c.ryi), .ryo(c.ryo), .rzhi(c.rzhi), .rzli(c.rzli), .rzho(c.rzho), .rzlo(c.rzlo),
        .rzo(c.rzo), .mem_read(c.mem_read), .mem_write(c.mem_write), .ipi(c.ipi), .ipo(c.ipo),
        .opi(c.opi), .input_unit(in_unit), .csigno(c.csigno), .gra(c.gra), .grb(c.grb),
        .grc(c.grc), .rin(c.rin), .rout(c.rout), .baout(c.baout),
        .bus_out(bus_out), .output_unit(output_unit)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want summary");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int          ia, ib;
        longint      p, q, r;
        int unsigned s;
        logic [31:0] t;
        ia = a; ib = b; s = b[4:0];
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd12: t = a + b;
            5'd4:           t = a - b;
            5'd5:           t = a >> s;
            5'd6:           t = ia >>> s;
            5'd7:           t = a << s;
            5'd8:           t = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            5'd9:           t = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            5'd10, 5'd13:   t = a & b;
            5'd11, 5'd14:   t = a | b;
            5'd15: begin
                if (ib == 0) return {a, 32'd0};
                q = longint'(ia) / longint'(ib);
                r = longint'(ia) % longint'(ib);
                return {r[31:0], q[31:0]};
            end
            5'd16: begin
                p = longint'(ia) * longint'(ib);
                return p;
            end
            5'd17:          t = 32'd0 - b;
            5'd18:          t = ~b;
            default:        t = b;
        endcase
        return {32'd0, t};
    endfunction

    function automatic logic [3:0] msel();
        return (c.gra ? m_ir[26:23] : 4'd0) | (c.grb ? m_ir[22:19] : 4'd0) | (c.grc ? m_ir[18:15] : 4'd0);
    endfunction

    task automatic model_eval(output logic [31:0] bus, output logic [31:0] alub);
        logic [3:0]  s;
        logic [31:0] lower;
        logic [63:0] z;
        s     = msel();
        lower = c.ipo ? m_in : (c.csigno ? {{13{m_ir[18]}}, m_ir[18:0]} : 32'd0);
        if      (c.rout)  bus = m_r[s];
        else if (c.baout) bus = (s == 4'd0) ? 32'd0 : m_r[s];
        else if (c.pco)   bus = m_pc;
        else if (c.iro)   bus = m_ir;
        else if (c.maro)  bus = {23'd0, m_mar};
        else if (c.mdro)  bus = m_mdr;
        else if (c.hio)   bus = m_hi;
        else if (c.loo)   bus = m_lo;
        else if (c.ryo)   bus = m_y;
        else if (c.rzho)  bus = m_zhi;
        else if (c.rzlo)  bus = m_zlo;
        else if (c.rzo) begin
            z    = alu_model(m_ir[31:27], m_y, lower);
            bus  = z[31:0];
            alub = lower;
            return;
        end
        else bus = lower;
        alub = bus;
    endtask

    task automatic drive();
        #3;
    endtask

    // Advance one clock: reference model and DUT both take the edge.
    task automatic edge_step();
        logic [31:0] bus, alub, rd;
        logic [63:0] alu;
        logic [3:0]  s;
        logic [8:0]  idx;
        model_eval(bus, alub);
        alu = alu_model(m_ir[31:27], m_y, alub);
        s   = msel();
        idx = m_mar;
        rd  = m_mem[idx];
        @(posedge clock);
        if (!clear) begin
            m_pc = pc_in; m_ir = ir_in; m_mar = '0; m_mdr = '0; m_y = '0; m_zhi = '0;
            m_zlo = '0; m_hi = '0; m_lo = '0; m_in = '0; m_out = '0;
            for (int i = 0; i < 16; i++) m_r[i] = '0;
        end else begin
            if (c.mem_write) begin m_mem[idx] = m_mdr; m_memv[idx] = 1'b1; end
            if (c.rin)  m_r[s] = bus;
            if (c.pci)  m_pc = c.pco ? (m_pc + pc_imm) : bus;
            if (c.iri)  m_ir = bus;
            if (c.mari) m_mar = bus[8:0];
            if (c.mdri) m_mdr = c.mem_read ? rd : bus;
            if (c.hii)  m_hi = bus;
            if (c.loi)  m_lo = bus;
            if (c.ryi)  m_y = bus;
            if (c.rzhi) m_zhi = alu[63:32];
            if (c.rzli) m_zlo = alu[31:0];
            if (c.ipi)  m_in = in_unit;
            if (c.opi)  m_out = bus;
        end
        #1;
    endtask

    task automatic cyc();
        drive();
        edge_step();
    endtask

    task automatic load_in(input logic [31:0] v);
        c = '0; clear = 1'b1; c.ipi = 1'b1; in_unit = v;
        cyc();
        c = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        c = '0; clear = 1'b0; pc_in = 32'h10; ir_in = 32'h0; pc_imm = '0; in_unit = '0;
        cyc();
        clear = 1'b1;
        drive();
        n_cmp++; if (bus_out !== 32'h0) begin n_bad++; $display("FAIL reset_bus: got %h want %h", bus_out, 32'h0); end
        n_cmp++; if (output_unit !== 32'h0) begin n_bad++; $display("FAIL reset_out: got %h want %h", output_unit, 32'h0); end
        edge_step();
        c.pco = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h10) begin n_bad++; $display("FAIL reset_pc: got %h want %h", bus_out, 32'h10); end
        edge_step();
        c = '0; c.iro = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h0) begin n_bad++; $display("FAIL reset_ir: got %h want %h", bus_out, 32'h0); end
        edge_step();
        c = '0;
    endtask

    task automatic test_ori();
        load_in(32'h7090_0005); c.ipo = 1'b1; c.mdri = 1'b1; cyc();
        c = '0; c.baout = 1'b1; c.mari = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h0) begin n_bad++; $display("FAIL ori_baout_r0: got %h want %h", bus_out, 32'h0); end
        edge_step();
        c = '0; c.mem_write = 1'b1; cyc();
        load_in(32'h0010_0000); c.ipo = 1'b1; c.iri = 1'b1; cyc();
        load_in(32'hF0); c.ipo = 1'b1; c.grb = 1'b1; c.rin = 1'b1; cyc();
        // instruction fetch and execute
        c = '0; c.baout = 1'b1; c.mari = 1'b1; cyc();
        c = '0; c.mem_read = 1'b1; c.mdri = 1'b1; cyc();
        c = '0; c.mdro = 1'b1; c.iri = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h7090_0005) begin n_bad++; $display("FAIL ori_fetch: got %h want %h", bus_out, 32'h7090_0005); end
        edge_step();
        c = '0; c.grb = 1'b1; c.rout = 1'b1; c.ryi = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'hF0) begin n_bad++; $display("FAIL ori_rb: got %h want %h", bus_out, 32'hF0); end
        edge_step();
        c = '0; c.csigno = 1'b1; c.rzli = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h5) begin n_bad++; $display("FAIL ori_imm: got %h want %h", bus_out, 32'h5); end
        edge_step();
        c = '0; c.rzlo = 1'b1; c.gra = 1'b1; c.rin = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'hF5) begin n_bad++; $display("FAIL ori_zlo: got %h want %h", bus_out, 32'hF5); end
        edge_step();
        c = '0; c.gra = 1'b1; c.rout = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'hF5) begin n_bad++; $display("FAIL ori_r1: got %h want %h", bus_out, 32'hF5); end
        edge_step();
        c = '0;
    endtask

    task automatic test_sign_ext();
        load_in(32'h0007_FFFF); c.ipo = 1'b1; c.iri = 1'b1; cyc();
        c = '0; c.csigno = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sign_ext: got %h want %h", bus_out, 32'hFFFF_FFFF); end
        edge_step();
        c = '0;
    endtask

    task automatic test_mul();
        load_in(32'h8000_0000); c.ipo = 1'b1; c.iri = 1'b1; cyc();
        load_in(32'hFFFF_FFFD); c.ipo = 1'b1; c.ryi = 1'b1; cyc();
        load_in(32'h7); c.ipo = 1'b1; c.rzhi = 1'b1; c.rzli = 1'b1; cyc();
        c = '0; c.rzho = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mul_hi: got %h want %h", bus_out, 32'hFFFF_FFFF); end
        edge_step();
        c = '0; c.rzlo = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul_lo: got %h want %h", bus_out, 32'hFFFF_FFEB); end
        edge_step();
        c = '0;
    endtask

    task automatic test_div_zero();
        load_in(32'h7800_0000); c.ipo = 1'b1; c.iri = 1'b1; cyc();
        load_in(32'h9); c.ipo = 1'b1; c.ryi = 1'b1; cyc();
        c = '0; c.rzhi = 1'b1; c.rzli = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h0) begin n_bad++; $display("FAIL div_idle_bus: got %h want %h", bus_out, 32'h0); end
        edge_step();
        c = '0; c.rzlo = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h0) begin n_bad++; $display("FAIL div0_lo: got %h want %h", bus_out, 32'h0); end
        edge_step();
        c = '0; c.rzho = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h9) begin n_bad++; $display("FAIL div0_hi: got %h want %h", bus_out, 32'h9); end
        edge_step();
        c = '0;
    endtask

    task automatic test_io_mem();
        load_in(32'hA5); c.ipo = 1'b1; c.opi = 1'b1; cyc();
        n_cmp++; if (output_unit !== 32'hA5) begin n_bad++; $display("FAIL io_out: got %h want %h", output_unit, 32'hA5); end
        load_in(32'h55); c.ipo = 1'b1; c.mdri = 1'b1; cyc();
        load_in(32'h3); c.ipo = 1'b1; c.mari = 1'b1; cyc();
        c = '0; c.mem_write = 1'b1; c.maro = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h3) begin n_bad++; $display("FAIL mem_mar: got %h want %h", bus_out, 32'h3); end
        edge_step();
        c = '0; c.mdri = 1'b1; cyc();
        c = '0; c.mdro = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h0) begin n_bad++; $display("FAIL mem_mdr_cleared: got %h want %h", bus_out, 32'h0); end
        edge_step();
        c = '0; c.mem_read = 1'b1; c.mdri = 1'b1; cyc();
        c = '0; c.mdro = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h55) begin n_bad++; $display("FAIL mem_readback: got %h want %h", bus_out, 32'h55); end
        edge_step();
        c = '0;
    endtask

    task automatic test_reset_override();
        load_in(32'h77);
        c.ipo = 1'b1; c.opi = 1'b1; c.pci = 1'b1; clear = 1'b0; pc_in = 32'h1234; ir_in = 32'h0;
        cyc();
        clear = 1'b1;
        n_cmp++; if (output_unit !== 32'h0) begin n_bad++; $display("FAIL reset_override_out: got %h want %h", output_unit, 32'h0); end
        c = '0; c.pco = 1'b1; drive();
        n_cmp++; if (bus_out !== 32'h1234) begin n_bad++; $display("FAIL reset_override_pc: got %h want %h", bus_out, 32'h1234); end
        edge_step();
        c = '0;
    endtask

    task automatic test_random();
        logic [31:0] exp_bus, alub;
        for (int n = 0; n < 3000; n++) begin
            clear = ($urandom_range(0, 63) != 0);
            c = '0;
            for (int b = 0; b < $bits(ctl_t); b++)
                if ($urandom_range(0, 9) == 0) c[b] = 1'b1;
            if (c.mem_read && !m_memv[m_mar]) c.mem_read = 1'b0;
            pc_in   = $urandom;
            ir_in   = $urandom;
            pc_imm  = $urandom;
            in_unit = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            model_eval(exp_bus, alub);
            drive();
            n_cmp++;
            if (bus_out !== exp_bus) begin
                n_bad++;
                $display("FAIL rand_bus[%0d]: got %h want %h", n, bus_out, exp_bus);
            end
            edge_step();
            n_cmp++;
            if (output_unit !== m_out) begin
                n_bad++;
                $display("FAIL rand_out[%0d]: got %h want %h", n, output_unit, m_out);
            end
        end
        c = '0; clear = 1'b1;
    endtask

    initial begin
        c = '0; clear = 1'b0; pc_in = '0; ir_in = '0; pc_imm = '0; in_unit = '0;
        for (int i = 0; i < 512; i++) begin m_mem[i] = '0; m_memv[i] = 1'b0; end
        test_reset();
        test_ori();
        test_sign_ext();
        test_mul();
        test_div_zero();
        test_io_mem();
        test_reset_override();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
